// File: rtl/disp_scan.sv
// ----------------------------------------------------------------------------
// disp_scan: binary-to-BCD converter and time-multiplexed 7-segment digit scan.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module disp_scan #(
  parameter int NDIGITS  = 4,
  parameter int WIDTH    = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   value,
  input  logic               load,
  input  logic [NDIGITS-1:0] dp_sel,
  input  logic               blank_lz,
  output logic               ready,
  output logic               ovf,
  output logic [3:0]         num,
  output logic               decimal,
  output logic [NDIGITS-1:0] digit_en
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * NDIGITS;

  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(10**NDIGITS - 1);
  localparam logic [PW-1:0]    PLAST = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]    CLAST = CW'(WIDTH - 1);
  localparam logic [IW-1:0]    ILAST = IW'(NDIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   bin_q;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic [CW-1:0]      cnt_q;
  logic [NDIGITS-1:0] dp_q;
  logic               blz_q, ovf_cap_q, ready_q, ovf_q;
  logic [3:0]         disp_q [NDIGITS];
  logic [3:0]         disp_d [NDIGITS];
  logic [NDIGITS-1:0] dpr_q, dpr_d;
  logic               lead_zero;

  logic [PW-1:0]      presc_q;
  logic [IW-1:0]      idx_q, idx_d;
  logic [3:0]         num_q;
  logic               dec_q;
  logic [NDIGITS-1:0] den_q;
  logic               wrap;

  assign ready    = ready_q;
  assign ovf      = ovf_q;
  assign num      = num_q;
  assign decimal  = dec_q;
  assign digit_en = den_q;

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next bit.
  always_comb begin
    bcd_d = bcd_q;
    for (int k = 0; k < NDIGITS; k++) begin
      if (bcd_d[4*k +: 4] >= 4'd5) begin
        bcd_d[4*k +: 4] = bcd_d[4*k +: 4] + 4'd3;
      end
    end
    bcd_d = {bcd_d[BW-2:0], bin_q[WIDTH-1]};
  end

  // Display contents to commit; a digit at or right of the decimal point is never blanked.
  always_comb begin
    disp_d    = '{default: 4'd15};
    dpr_d     = '0;
    lead_zero = 1'b1;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      lead_zero = lead_zero & (bcd_q[4*k +: 4] == 4'd0);
      if (ovf_cap_q) begin
        disp_d[k] = 4'd10;
        dpr_d[k]  = 1'b0;
      end else begin
        disp_d[k] = (blz_q && lead_zero && (k != 0) && ((dp_q >> k) == '0))
                    ? 4'd15 : bcd_q[4*k +: 4];
        dpr_d[k]  = dp_q[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      ovf_q     <= 1'b0;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      dp_q      <= '0;
      blz_q     <= 1'b0;
      ovf_cap_q <= 1'b0;
      disp_q    <= '{default: 4'd15};
      dpr_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load) begin
            bin_q     <= value;
            dp_q      <= dp_sel;
            blz_q     <= blank_lz;
            ovf_cap_q <= (value > MAXV);
            bcd_q     <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            state_q   <= S_CONV;
          end
        end
        S_CONV: begin
          bcd_q <= bcd_d;
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CLAST) begin
            state_q <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          disp_q  <= disp_d;
          dpr_q   <= dpr_d;
          ovf_q   <= ovf_cap_q;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Until the first wrap no digit is enabled, so the first slot shown is digit 0.
  assign wrap  = (presc_q == PLAST);
  assign idx_d = (&den_q) ? '0 : ((idx_q == ILAST) ? '0 : idx_q + 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      num_q   <= 4'd15;
      dec_q   <= 1'b0;
      den_q   <= '1;
    end else begin
      presc_q <= wrap ? '0 : presc_q + 1'b1;
      if (wrap) begin
        idx_q <= idx_d;
        num_q <= disp_q[idx_d];
        dec_q <= dpr_q[idx_d];
        den_q <= ~(NDIGITS'(1) << idx_d);
      end
    end
  end

endmodule

`default_nettype wire
